// File: rtl/ldpc_syndrome_check.sv
// rtl/ldpc_syndrome_check.sv - serial LDPC syndrome checker (recompute parity, compare, count mismatches)
//
// Purpose: receives a hard-decision codeword one bit per valid cycle (K info bits, then Z
// parity bits), recomputes the parity with the encoder's circulant-row ROM and reports
// pass/fail plus the number of mismatching parity bits for each frame.
//
// Ports:
//   clk        in   1       clock
//   rst_n      in   1       synchronous active-low reset
//   din_valid  in   1       din qualifier; gaps of any length allowed
//   din        in   1       codeword bit (info first, then parity MSB first)
//   sof        in   1       first info bit marker, sampled only with din_valid=1
//   rom_addr   out  ROM_AW  generator ROM row select
//   rom_data   in   Z       generator ROM row, valid 1 cycle after rom_addr
//   busy       out  1       frame in progress
//   done       out  1       1-cycle pulse after the last parity bit
//   frame_ok   out  1       no parity mismatches; held until next done
//   err_cnt    out  9       mismatching parity bits; held until next done
module ldpc_syndrome_check #(
  parameter int Z      = 360,
  parameter int NGRP   = 12,
  parameter int ROM_AW = 4,
  parameter int CNT_W  = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din_valid,
  input  logic              din,
  input  logic              sof,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [Z-1:0]      rom_data,
  output logic              busy,
  output logic              done,
  output logic              frame_ok,
  output logic [8:0]        err_cnt
);

  localparam int K    = Z * NGRP;
  localparam int GP_W = $clog2(Z);

  localparam logic [CNT_W-1:0]  LAST_INFO = CNT_W'(K - 1);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(K + Z - 1);
  localparam logic [GP_W-1:0]   GPOS_LAST = GP_W'(Z - 1);
  localparam logic [ROM_AW-1:0] ADDR_LAST = ROM_AW'(NGRP - 1);
  localparam logic [8:0]        ERR_MAX   = 9'(Z);

  typedef enum logic [1:0] {
    S_IDLE,
    S_INFO,
    S_PARITY,
    S_REFETCH
  } state_t;

  state_t           state;
  logic [Z-1:0]     acc;        // running parity; shifted out MSB first during PARITY
  logic [Z-1:0]     rot;        // current group row rotated for the next info bit
  logic [Z-1:0]     next_row;   // prefetched row for the next group boundary
  logic [CNT_W-1:0] cnt;        // index of the next codeword bit
  logic [GP_W-1:0]  gpos;       // index of the next bit within its group
  logic [8:0]       err;
  logic             held;       // sof bit parked while row0 is refetched

  function automatic logic [Z-1:0] rotr(input logic [Z-1:0] x);
    return {x[0], x[Z-1:1]};
  endfunction

  // Values for starting a frame straight off rom_data (row0 is being presented).
  logic [Z-1:0] start_acc;
  logic [Z-1:0] row0_rot1;
  logic [Z-1:0] row0_rot2;
  logic [Z-1:0] refetch_acc;
  logic         mismatch;
  logic [8:0]   err_next;

  always_comb begin
    start_acc   = din ? rom_data : '0;
    row0_rot1   = rotr(rom_data);
    row0_rot2   = rotr(row0_rot1);
    // Parked sof bit applied with row0; a same-cycle second bit uses row0 rotated once.
    refetch_acc = (held ? rom_data : '0) ^ ((din_valid && din) ? row0_rot1 : '0);
    mismatch    = din ^ acc[Z-1];
    err_next    = err;
    if (mismatch && (err != ERR_MAX)) begin
      err_next = err + 9'd1;
    end
  end

  // rom_addr only moves at group boundaries, so capturing every cycle keeps next_row
  // equal to the row one cycle after each address change.
  always_ff @(posedge clk) begin
    next_row <= rom_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      acc      <= '0;
      rot      <= '0;
      cnt      <= '0;
      gpos     <= '0;
      err      <= '0;
      held     <= 1'b0;
      rom_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      frame_ok <= 1'b0;
      err_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (din_valid && sof) begin
            acc      <= start_acc;
            rot      <= row0_rot1;
            cnt      <= CNT_W'(1);
            gpos     <= GP_W'(1);
            err      <= '0;
            rom_addr <= ROM_AW'(1);
            busy     <= 1'b1;
            state    <= S_INFO;
          end
        end

        S_REFETCH: begin
          // rom_addr went to 0 last cycle, so rom_data now carries row0.
          if (din_valid && sof) begin
            acc      <= start_acc;
            rot      <= row0_rot1;
            cnt      <= CNT_W'(1);
            gpos     <= GP_W'(1);
          end else if (din_valid) begin
            acc      <= refetch_acc;
            rot      <= row0_rot2;
            cnt      <= CNT_W'(2);
            gpos     <= GP_W'(2);
          end else begin
            acc      <= refetch_acc;
            rot      <= row0_rot1;
            cnt      <= CNT_W'(1);
            gpos     <= GP_W'(1);
          end
          err      <= '0;
          rom_addr <= ROM_AW'(1);
          state    <= S_INFO;
        end

        S_INFO: begin
          if (din_valid && sof) begin
            held     <= din;
            rom_addr <= '0;
            state    <= S_REFETCH;
          end else if (din_valid) begin
            if (gpos == '0) begin
              acc <= acc ^ (din ? next_row : '0);
              rot <= rotr(next_row);
              if (rom_addr != ADDR_LAST) begin
                rom_addr <= rom_addr + ROM_AW'(1);
              end
            end else begin
              acc <= acc ^ (din ? rot : '0);
              rot <= rotr(rot);
            end
            gpos <= (gpos == GPOS_LAST) ? '0 : gpos + GP_W'(1);
            cnt  <= cnt + CNT_W'(1);
            if (cnt == LAST_INFO) begin
              rom_addr <= '0;
              state    <= S_PARITY;
            end
          end
        end

        S_PARITY: begin
          if (din_valid && sof) begin
            held     <= din;
            rom_addr <= '0;
            state    <= S_REFETCH;
          end else if (din_valid) begin
            acc <= {acc[Z-2:0], 1'b0};
            err <= err_next;
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST_BIT) begin
              cnt      <= '0;
              busy     <= 1'b0;
              done     <= 1'b1;
              err_cnt  <= err_next;
              frame_ok <= (err_next == 9'd0);
              state    <= S_IDLE;
            end
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ldpc_syndrome_check.sv
// tb/tb_ldpc_syndrome_check.sv - self-checking bench for ldpc_syndrome_check
module tb_ldpc_syndrome_check;

  localparam int Z      = 360;
  localparam int NGRP   = 12;
  localparam int ROM_AW = 4;
  localparam int CNT_W  = 13;
  localparam int K      = Z * NGRP;
  localparam int N      = K + Z;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              din_valid = 1'b0;
  logic              din = 1'b0;
  logic              sof = 1'b0;
  logic [ROM_AW-1:0] rom_addr;
  logic [Z-1:0]      rom_data;
  logic              busy;
  logic              done;
  logic              frame_ok;
  logic [8:0]        err_cnt;

  int checks = 0;
  int failures = 0;

  logic [Z-1:0] rom [16];
  logic         info [K];
  logic [Z-1:0] par_true;
  logic [Z-1:0] par_tx;
  logic [9:0]   exp_q [$];

  always #5 clk = ~clk;

  // Generator ROM: rom_data settles within the cycle after rom_addr changes.
  assign rom_data = rom[rom_addr];

  ldpc_syndrome_check #(.Z(Z), .NGRP(NGRP), .ROM_AW(ROM_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .sof(sof),
    .rom_addr(rom_addr), .rom_data(rom_data), .busy(busy), .done(done),
    .frame_ok(frame_ok), .err_cnt(err_cnt)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [Z-1:0] rotr_n(input logic [Z-1:0] x, input int r);
    logic [2*Z-1:0] d;
    d = {x, x} >> r;
    return d[Z-1:0];
  endfunction

  // Encoder reference: every set info bit i adds row[i/Z] rotated right by i%Z.
  task automatic calc_parity();
    par_true = '0;
    for (int i = 0; i < K; i++) begin
      if (info[i]) par_true ^= rotr_n(rom[i / Z], i % Z);
    end
    par_tx = par_true;
  endtask

  task automatic push_exp();
    int e;
    e = $countones(par_tx ^ par_true);
    exp_q.push_back({(e == 0), 9'(e)});
  endtask

  task automatic drive(input logic b, input logic s);
    din_valid = 1'b1;
    din = b;
    sof = s;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    din = 1'b0;
    sof = 1'b0;
  endtask

  task automatic send_frame(input int nbits, input bit gapped, input bit chk_hold);
    logic b;
    for (int n = 0; n < nbits; n++) begin
      if (gapped) begin
        while ($urandom_range(0, 1) == 1) begin
          @(posedge clk);
          #1;
        end
      end
      if (chk_hold && n == nbits - 1) begin
        chk("held_frame_ok", 16'(frame_ok), 16'd0);
        chk("held_err_cnt", 16'(err_cnt), 16'd0);
      end
      b = (n < K) ? info[n] : par_tx[Z-1-(n-K)];
      drive(b, n == 0);
    end
  endtask

  task automatic run_full(input bit gapped, input bit chk_hold);
    push_exp();
    send_frame(N, gapped, chk_hold);
    @(negedge clk);
    chk("done_pulse", 16'(done), 16'd1);
    @(negedge clk);
    chk("done_low", 16'(done), 16'd0);
  endtask

  task automatic fill_info(input int mode);
    for (int i = 0; i < K; i++) begin
      info[i] = (mode == 0) ? 1'b0 : (mode == 1) ? (i == 0) : 1'($urandom_range(0, 1));
    end
    calc_parity();
  endtask

  // Scoreboard: each done pops the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      chk("done_expected", 16'(exp_q.size() > 0), 16'd1);
      if (exp_q.size() > 0) begin
        logic [9:0] e;
        e = exp_q.pop_front();
        chk("frame_ok", 16'(frame_ok), 16'(e[9]));
        chk("err_cnt", 16'(err_cnt), 16'(e[8:0]));
      end
    end
  end

  initial begin
    for (int g = 0; g < 16; g++) begin
      for (int b = 0; b < Z; b++) begin
        rom[g][b] = (g < NGRP) ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_frame_ok", 16'(frame_ok), 16'd0);
    chk("rst_err_cnt", 16'(err_cnt), 16'd0);
    chk("rst_rom_addr", 16'(rom_addr), 16'd0);

    // All-zero frame.
    fill_info(0);
    run_full(1'b0, 1'b0);

    // Info bit 0 only: parity equals row0.
    fill_info(1);
    chk("model_row0", 16'(par_true == rom[0]), 16'd1);
    run_full(1'b0, 1'b0);

    // Same frame, parity bit j=5 flipped.
    par_tx[Z-1-5] = ~par_tx[Z-1-5];
    run_full(1'b0, 1'b0);

    // Random frame gapless, then the same frame with 50% valid duty.
    fill_info(2);
    run_full(1'b0, 1'b0);
    run_full(1'b1, 1'b0);

    // All parity bits inverted.
    par_tx = ~par_true;
    run_full(1'b0, 1'b0);

    // Frame A aborted at bit 1000 by frame B (three parity errors) sent back-to-back.
    fill_info(2);
    send_frame(1000, 1'b0, 1'b0);
    fill_info(2);
    par_tx[0] = ~par_tx[0];
    par_tx[100] = ~par_tx[100];
    par_tx[Z-1] = ~par_tx[Z-1];
    run_full(1'b0, 1'b0);

    // Abort during parity, restart frame C with gaps.
    fill_info(2);
    send_frame(K + 100, 1'b0, 1'b0);
    chk("busy_in_parity", 16'(busy), 16'd1);
    fill_info(2);
    run_full(1'b1, 1'b0);

    // Reset for one cycle at bit 2000, then a full valid frame.
    fill_info(2);
    send_frame(2000, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 16'(busy), 16'd0);
    chk("mid_rst_frame_ok", 16'(frame_ok), 16'd0);
    chk("mid_rst_err_cnt", 16'(err_cnt), 16'd0);
    chk("mid_rst_rom_addr", 16'(rom_addr), 16'd0);
    fill_info(2);
    run_full(1'b0, 1'b1);

    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clk);
    chk("scoreboard_empty", 16'(exp_q.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
